dmem_responder: RTL

Byte-addressable data-memory responder serving the core's load/store traffic over a valid/ready request channel and a valid/ready response channel. It accepts one request at a time and inserts a configurable number of wait states. It performs little-endian byte, half-word and word accesses, applying sign or zero extension to loads, and flags misaligned or out-of-range requests. It sits between the MEM stage of the core and its data storage, replacing the flattened scratchpad with a handshaked memory that can stall the pipeline.

---
 rtl/dmem_responder.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Handshaked byte-addressable data memory for the core's MEM stage: one request
// at a time, LATENCY wait states, little-endian b/h/w access with load extension.
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [7:0] mem_q [DEPTH];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        we_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        cap_en;
    logic        do_access;

    logic        acc_we;
    logic [31:0] acc_addr;
    logic [1:0]  acc_size;
    logic        acc_uns;
    logic [31:0] acc_wdata;
    logic        acc_err;

    logic [ADDR_WIDTH-3:0] widx;
    logic [31:0] rd_word;
    logic [31:0] load_ext;
    logic [3:0]  be;
    logic [31:0] wlane;
    logic        mem_we;

    // With LATENCY = 0 the access happens on the acceptance edge, so it must
    // use the live request inputs instead of the captured copy.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = req_we_i;
            acc_addr  = req_addr_i;
            acc_size  = req_size_i;
            acc_uns   = req_unsigned_i;
            acc_wdata = req_wdata_i;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_size  = size_q;
            acc_uns   = uns_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        acc_err = 1'b0;
        if (acc_addr[31:ADDR_WIDTH] != '0) begin
            acc_err = 1'b1;
        end
        case (acc_size)
            2'b01:   if (acc_addr[0]) acc_err = 1'b1;
            2'b10:   if (acc_addr[1:0] != 2'b00) acc_err = 1'b1;
            2'b11:   acc_err = 1'b1;
            default: ;
        endcase
    end

    assign widx    = acc_addr[ADDR_WIDTH-1:2];
    assign rd_word = {mem_q[{widx, 2'd3}], mem_q[{widx, 2'd2}],
                      mem_q[{widx, 2'd1}], mem_q[{widx, 2'd0}]};

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        load_ext = '0;
        case (acc_addr[1:0])
            2'd0:    b = rd_word[7:0];
            2'd1:    b = rd_word[15:8];
            2'd2:    b = rd_word[23:16];
            default: b = rd_word[31:24];
        endcase
        h = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (acc_size)
            2'b00:   load_ext = acc_uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   load_ext = acc_uns ? {16'd0, h} : {{16{h[15]}}, h};
            2'b10:   load_ext = rd_word;
            default: load_ext = '0;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the target.
    always_comb begin
        be    = 4'b0000;
        wlane = '0;
        case (acc_size)
            2'b00: begin
                be    = 4'b0001 << acc_addr[1:0];
                wlane = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                be    = acc_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{acc_wdata[15:0]}};
            end
            2'b10: begin
                be    = 4'b1111;
                wlane = acc_wdata;
            end
            default: ;
        endcase
    end

    assign mem_we = do_access & acc_we & ~acc_err & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[{widx, 2'(i)}] <= wlane[8*i +: 8];
                end
            end
        end
    end

    assign accept = req_valid_i & (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cap_en      = 1'b0;
        do_access   = 1'b0;
        req_ready_o = (state_q == IDLE) & ~rst_i;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cap_en = 1'b1;
                    if (LATENCY == 0) begin
                        do_access = 1'b1;
                        state_d   = RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (do_access) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = (acc_we || acc_err) ? '0 : load_ext;
            rsp_err_d   = acc_err;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (cap_en) begin
                we_q    <= req_we_i;
                addr_q  <= req_addr_i;
                size_q  <= req_size_i;
                uns_q   <= req_unsigned_i;
                wdata_q <= req_wdata_i;
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
